pipe_stage_hs: RTL and testbench



---
 rtl/pipe_stage_hs.sv | 57 +++++
 tb/tb_pipe_stage_hs.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: STAGES-deep valid/ready pipeline slice with flush and set_data reset value; ports clk, rst_n, set_data, flush, i_valid/i_ready/data_i (upstream), o_valid/o_ready/data_o (downstream), count (occupancy)
module pipe_stage_hs #(
  parameter int DW = 32,
  parameter int STAGES = 1,
  parameter int CW = $clog2(STAGES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] set_data,
  input  logic          flush,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] data_i,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] data_o,
  output logic [CW-1:0] count
);
  logic [STAGES-1:0] valid;
  logic [DW-1:0]     data [STAGES];
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] in_v;
  logic [DW-1:0]     src [STAGES];
  logic              in_x;
  logic              out_x;
  genvar g;
  for (g = 0; g < STAGES; g++) begin : g_rdy
    // a stage can load if the output drains or any stage at or after it is empty
    assign rdy[g] = o_ready | ~&valid[STAGES-1:g];
  end
  for (g = 1; g < STAGES; g++) begin : g_src
    assign in_v[g] = valid[g-1];
    assign src[g]  = data[g-1];
  end
  assign i_ready  = rdy[0] & ~flush;
  assign in_v[0]  = i_valid & i_ready;
  assign src[0]   = data_i;
  assign in_x     = in_v[0];
  assign out_x    = valid[STAGES-1] & o_ready;
  assign o_valid  = valid[STAGES-1];
  assign data_o   = data[STAGES-1];
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      valid <= '0;
      count <= '0;
      for (int k = 0; k < STAGES; k++) data[k] <= set_data;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          valid[k] <= in_v[k];
          if (in_v[k]) data[k] <= src[k];
        end
      end
      count <= (in_x && !out_x) ? count + CW'(1) : (!in_x && out_x) ? count - CW'(1) : count;
    end
  end
endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: directed checks of a 3-stage slice plus a scoreboarded random run of a 1-stage slice
module tb_pipe_stage_hs;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        flush = 0;
  logic [31:0] set_data = 32'hDEAD_BEEF;
  logic        iv3 = 0, ordy3 = 0, irdy3, ov3;
  logic [31:0] di3 = 0, dout3;
  logic [1:0]  cnt3;
  logic        iv1 = 0, ordy1 = 0, irdy1, ov1;
  logic [31:0] di1 = 0, dout1;
  logic [0:0]  cnt1;
  int n_checks = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  pipe_stage_hs #(.DW(32), .STAGES(3)) d3 (
    .clk(clk), .rst_n(rst_n), .set_data(set_data), .flush(flush),
    .i_valid(iv3), .i_ready(irdy3), .data_i(di3),
    .o_valid(ov3), .o_ready(ordy3), .data_o(dout3), .count(cnt3)
  );
  pipe_stage_hs #(.DW(32), .STAGES(1)) d1 (
    .clk(clk), .rst_n(rst_n), .set_data(set_data), .flush(flush),
    .i_valid(iv1), .i_ready(irdy1), .data_i(di1),
    .o_valid(ov1), .o_ready(ordy1), .data_o(dout1), .count(cnt1)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 0; iv3 = 0; ordy3 = 0; iv1 = 0; ordy1 = 0; flush = 0;
    step();
    rst_n = 1;
    #1;
  endtask
  task automatic test_reset();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    #1;
    n_checks++; if (ov3 !== 1'b0) $display("FAIL reset_ovalid got %0h want 0", ov3); else n_pass++;
    n_checks++; if (cnt3 !== 2'd0) $display("FAIL reset_count got %0d want 0", cnt3); else n_pass++;
    n_checks++; if (dout3 !== 32'hDEAD_BEEF) $display("FAIL reset_data got %0h want deadbeef", dout3); else n_pass++;
    n_checks++; if (irdy3 !== 1'b1) $display("FAIL reset_iready got %0h want 1", irdy3); else n_pass++;
  endtask
  task automatic test_stream();
    do_reset();
    ordy3 = 1;
    for (int c = 0; c < 8; c++) begin
      iv3 = 1; di3 = c + 1;
      step();
      n_checks++; if (ov3 !== (c >= 2)) $display("FAIL stream_ovalid[%0d] got %0h want %0h", c, ov3, c >= 2); else n_pass++;
      n_checks++; if (cnt3 !== 2'((c < 2) ? c + 1 : 3)) $display("FAIL stream_count[%0d] got %0d want %0d", c, cnt3, (c < 2) ? c + 1 : 3); else n_pass++;
      if (c >= 2) begin
        n_checks++; if (dout3 !== 32'(c - 1)) $display("FAIL stream_data[%0d] got %0h want %0h", c, dout3, c - 1); else n_pass++;
      end
    end
    iv3 = 0;
    step();
    n_checks++; if (dout3 !== 32'd7 || cnt3 !== 2'd2) $display("FAIL stream_drain7 got %0h/%0d want 7/2", dout3, cnt3); else n_pass++;
    step();
    n_checks++; if (dout3 !== 32'd8 || cnt3 !== 2'd1) $display("FAIL stream_drain8 got %0h/%0d want 8/1", dout3, cnt3); else n_pass++;
    step();
    n_checks++; if (ov3 !== 1'b0 || cnt3 !== 2'd0) $display("FAIL stream_empty got %0h/%0d want 0/0", ov3, cnt3); else n_pass++;
  endtask
  task automatic test_backpressure();
    do_reset();
    ordy3 = 0;
    iv3 = 1; di3 = 32'hA; step();
    di3 = 32'hB; step();
    di3 = 32'hC; step();
    di3 = 32'hD;
    #1;
    n_checks++; if (cnt3 !== 2'd3) $display("FAIL bp_full_count got %0d want 3", cnt3); else n_pass++;
    n_checks++; if (irdy3 !== 1'b0) $display("FAIL bp_full_iready got %0h want 0", irdy3); else n_pass++;
    n_checks++; if (ov3 !== 1'b1 || dout3 !== 32'hA) $display("FAIL bp_full_out got %0h/%0h want 1/a", ov3, dout3); else n_pass++;
    step();
    n_checks++; if (dout3 !== 32'hA || cnt3 !== 2'd3) $display("FAIL bp_stall got %0h/%0d want a/3", dout3, cnt3); else n_pass++;
    ordy3 = 1;
    #1;
    n_checks++; if (irdy3 !== 1'b1) $display("FAIL bp_release_iready got %0h want 1", irdy3); else n_pass++;
    step();
    ordy3 = 0; iv3 = 0;
    #1;
    n_checks++; if (dout3 !== 32'hB || cnt3 !== 2'd3) $display("FAIL bp_swap got %0h/%0d want b/3", dout3, cnt3); else n_pass++;
    ordy3 = 1;
    step();
    n_checks++; if (dout3 !== 32'hC) $display("FAIL bp_drain_c got %0h want c", dout3); else n_pass++;
    step();
    n_checks++; if (dout3 !== 32'hD || ov3 !== 1'b1) $display("FAIL bp_drain_d got %0h/%0h want d/1", dout3, ov3); else n_pass++;
    step();
    n_checks++; if (ov3 !== 1'b0 || cnt3 !== 2'd0) $display("FAIL bp_empty got %0h/%0d want 0/0", ov3, cnt3); else n_pass++;
  endtask
  task automatic test_bubble();
    do_reset();
    ordy3 = 0;
    iv3 = 1; di3 = 32'h55; step();
    iv3 = 0; step(); step();
    n_checks++; if (ov3 !== 1'b1 || dout3 !== 32'h55 || cnt3 !== 2'd1) $display("FAIL bubble_single got %0h/%0h/%0d want 1/55/1", ov3, dout3, cnt3); else n_pass++;
    n_checks++; if (irdy3 !== 1'b1) $display("FAIL bubble_iready got %0h want 1", irdy3); else n_pass++;
    iv3 = 1; di3 = 32'h66; step();
    di3 = 32'h77; step();
    iv3 = 0;
    #1;
    n_checks++; if (cnt3 !== 2'd3 || irdy3 !== 1'b0) $display("FAIL bubble_full got %0d/%0h want 3/0", cnt3, irdy3); else n_pass++;
    n_checks++; if (dout3 !== 32'h55) $display("FAIL bubble_head got %0h want 55", dout3); else n_pass++;
    ordy3 = 1;
    step();
    n_checks++; if (dout3 !== 32'h66) $display("FAIL bubble_order1 got %0h want 66", dout3); else n_pass++;
    step();
    n_checks++; if (dout3 !== 32'h77) $display("FAIL bubble_order2 got %0h want 77", dout3); else n_pass++;
    step();
    n_checks++; if (ov3 !== 1'b0) $display("FAIL bubble_empty got %0h want 0", ov3); else n_pass++;
  endtask
  task automatic test_flush();
    do_reset();
    ordy3 = 0;
    iv3 = 1; di3 = 32'h11; step();
    iv3 = 0; step(); step();
    iv3 = 1; di3 = 32'h22; step();
    iv3 = 1; di3 = 32'h77; flush = 1; ordy3 = 1;
    #1;
    n_checks++; if (cnt3 !== 2'd2) $display("FAIL flush_pre_count got %0d want 2", cnt3); else n_pass++;
    n_checks++; if (irdy3 !== 1'b0) $display("FAIL flush_iready got %0h want 0", irdy3); else n_pass++;
    n_checks++; if (ov3 !== 1'b1 || dout3 !== 32'h11) $display("FAIL flush_pre_out got %0h/%0h want 1/11", ov3, dout3); else n_pass++;
    step();
    flush = 0; iv3 = 0;
    #1;
    n_checks++; if (ov3 !== 1'b0 || cnt3 !== 2'd0) $display("FAIL flush_post got %0h/%0d want 0/0", ov3, cnt3); else n_pass++;
    n_checks++; if (dout3 !== 32'hDEAD_BEEF) $display("FAIL flush_data got %0h want deadbeef", dout3); else n_pass++;
    n_checks++; if (irdy3 !== 1'b1) $display("FAIL flush_post_iready got %0h want 1", irdy3); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++; if (ov3 !== 1'b0) $display("FAIL flush_lost[%0d] got %0h want 0", c, ov3); else n_pass++;
    end
  endtask
  task automatic test_random_s1();
    logic [31:0] q[$];
    logic [31:0] exp_d;
    logic in_x, out_x;
    do_reset();
    iv1 = 0; ordy1 = 0;
    for (int c = 0; c < 1000; c++) begin
      #1;
      in_x = iv1 && irdy1;
      out_x = ov1 && ordy1;
      n_checks++; if (ov1 !== (q.size() != 0)) $display("FAIL rnd_ovalid[%0d] got %0h want %0h", c, ov1, q.size() != 0); else n_pass++;
      n_checks++; if (cnt1 !== 1'(ov1)) $display("FAIL rnd_count[%0d] got %0d want %0d", c, cnt1, ov1); else n_pass++;
      n_checks++; if (irdy1 !== (q.size() == 0 || ordy1)) $display("FAIL rnd_iready[%0d] got %0h want %0h", c, irdy1, q.size() == 0 || ordy1); else n_pass++;
      if (out_x && q.size() != 0) begin
        exp_d = q.pop_front();
        n_checks++; if (dout1 !== exp_d) $display("FAIL rnd_data[%0d] got %0h want %0h", c, dout1, exp_d); else n_pass++;
      end
      if (in_x) q.push_back(di1);
      step();
      if (!(iv1 && !in_x)) begin
        iv1 = 1'($urandom_range(0, 1));
        di1 = $urandom;
      end
      ordy1 = 1'($urandom_range(0, 1));
    end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_random_s1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
